// File: rtl/dl_arb_pkg.sv
// Shared types for the download/CPU RAM arbiter: FSM states and the FIFO entry layout.
package dl_arb_pkg;

   localparam int unsigned DL_ADDR_W = 25;
   localparam int unsigned DL_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DL_WR   = 2'd1,
      CPU_ACC = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [DL_ADDR_W-1:0] addr;
      logic [DL_DATA_W-1:0] data;
   } dl_entry_t;

endpackage

// File: rtl/dl_fifo.sv
// Parameterised synchronous FIFO with show-ahead head, full/empty and an occupancy count.
module dl_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = logic [7:0],
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  T                 din_i,
   output T                 head_c,
   output logic             full_c,
   output logic             empty_c,
   output logic [CNT_W-1:0] count_o
);

   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   T                 mem_q [DEPTH];
   logic             pop_ok;
   logic             push_ok;

   assign empty_c = (count_q == '0);
   assign full_c  = (count_q == CNT_W'(DEPTH));
   assign pop_ok  = pop_i & ~empty_c;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok = push_i & (~full_c | pop_ok);
   assign head_c  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/dl_ram_arbiter.sv
// Shares one RAM port between buffered download writes (always first) and CPU req/ack accesses.
// Optional macro DL_ARB_CHECKSUM_EN adds dl_csum, a mod-256 sum of download bytes written to RAM.
module dl_ram_arbiter
   import dl_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = DL_ADDR_W,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              dl_active,
   input  logic              dl_wr,
   input  logic [ADDR_W-1:0] dl_addr,
   input  logic [7:0]        dl_data,
   output logic              dl_overflow,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_hold,
   output logic              ram_req,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   input  logic              ram_ack
`ifdef DL_ARB_CHECKSUM_EN
   ,
   output logic [7:0]        dl_csum
`endif
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   arb_state_e        state_q, state_d;
   logic              ram_req_q, ram_req_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]        ram_wdata_q, ram_wdata_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic [7:0]        cpu_rdata_q, cpu_rdata_d;
   logic              ovf_q, ovf_d;
   logic              act_q;

   dl_entry_t         push_e;
   dl_entry_t         fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_cnt;
   logic              fifo_pop;
   logic              hold_c;
   logic              dl_rise;
   logic              dl_drop;

   // Entry address field is DL_ADDR_W wide; ADDR_W is expected not to exceed it.
   assign push_e = {DL_ADDR_W'(dl_addr), dl_data};

   dl_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (dl_entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .push_i  (dl_wr),
      .pop_i   (fifo_pop),
      .din_i   (push_e),
      .head_c  (fifo_head),
      .full_c  (fifo_full),
      .empty_c (fifo_empty),
      .count_o (fifo_cnt)
   );

   assign hold_c   = dl_active | (fifo_cnt != '0);
   assign cpu_hold = reset_n & hold_c;
   assign dl_rise  = dl_active & ~act_q;
   assign dl_drop  = dl_wr & fifo_full & ~fifo_pop;
   // A drop in the same cycle as a dl_active rise still leaves the flag set.
   assign ovf_d    = (ovf_q & ~dl_rise) | dl_drop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!fifo_empty)              state_d = DL_WR;
            else if (cpu_req && !hold_c)  state_d = CPU_ACC;
         end
         DL_WR:   if (ram_ack) state_d = IDLE;
         CPU_ACC: if (ram_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fifo_pop    = 1'b0;
      ram_req_d   = ram_req_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      cpu_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop    = 1'b1;
               ram_req_d   = 1'b1;
               ram_we_d    = 1'b1;
               ram_addr_d  = ADDR_W'(fifo_head.addr);
               ram_wdata_d = fifo_head.data;
            end else if (cpu_req && !hold_c) begin
               ram_req_d   = 1'b1;
               ram_we_d    = cpu_we;
               ram_addr_d  = cpu_addr;
               ram_wdata_d = cpu_wdata;
            end
         end
         DL_WR: begin
            if (ram_ack) begin
               ram_req_d = 1'b0;
               ram_we_d  = 1'b0;
            end
         end
         CPU_ACC: begin
            if (ram_ack) begin
               ram_req_d = 1'b0;
               ram_we_d  = 1'b0;
               cpu_ack_d = 1'b1;
               if (!ram_we_q) cpu_rdata_d = ram_rdata;
            end
         end
         default: begin
            ram_req_d = 1'b0;
            ram_we_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ram_req_q   <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         ovf_q       <= 1'b0;
         act_q       <= 1'b0;
      end else begin
         ram_req_q   <= ram_req_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         cpu_ack_q   <= cpu_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         ovf_q       <= ovf_d;
         act_q       <= dl_active;
      end
   end

   assign ram_req     = ram_req_q;
   assign ram_we      = ram_we_q;
   assign ram_addr    = ram_addr_q;
   assign ram_wdata   = ram_wdata_q;
   assign cpu_ack     = cpu_ack_q;
   assign cpu_rdata   = cpu_rdata_q;
   assign dl_overflow = ovf_q;

`ifdef DL_ARB_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;

   // Clear on a new download, then add the byte whose write completes this cycle.
   always_comb begin
      csum_d = dl_rise ? 8'h00 : csum_q;
      if (state_q == DL_WR && ram_ack) csum_d = csum_d + ram_wdata_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) csum_q <= 8'h00;
      else          csum_q <= csum_d;
   end

   assign dl_csum = csum_q;
`endif

endmodule

// File: tb/tb_dl_ram_arbiter.sv
// Randomised bench for dl_ram_arbiter with a queue-based reference model and directed scenarios.
// Also exercises dl_csum when DL_ARB_CHECKSUM_EN is defined.
module tb_dl_ram_arbiter;

   localparam int AW    = 25;
   localparam int DEPTH = 4;

   logic          clk;
   logic          reset_n;
   logic          dl_active;
   logic          dl_wr;
   logic [AW-1:0] dl_addr;
   logic [7:0]    dl_data;
   logic          dl_overflow;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_wdata;
   logic [7:0]    cpu_rdata;
   logic          cpu_ack;
   logic          cpu_hold;
   logic          ram_req;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_wdata;
   logic [7:0]    ram_rdata;
   logic          ram_ack;
`ifdef DL_ARB_CHECKSUM_EN
   logic [7:0]    dl_csum;
`endif

   dl_ram_arbiter #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .dl_active   (dl_active),
      .dl_wr       (dl_wr),
      .dl_addr     (dl_addr),
      .dl_data     (dl_data),
      .dl_overflow (dl_overflow),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_ack     (cpu_ack),
      .cpu_hold    (cpu_hold),
      .ram_req     (ram_req),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata),
      .ram_ack     (ram_ack)
`ifdef DL_ARB_CHECKSUM_EN
      ,
      .dl_csum     (dl_csum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: pending download bytes as a queue plus the in-flight access.
   logic [32:0]   mq[$];
   int            m_owner;      // 0 none, 1 download, 2 cpu
   bit            m_req, m_we, m_ack, m_ovf, m_act_prev;
   logic [AW-1:0] m_addr;
   logic [7:0]    m_wdata, m_rdata;
`ifdef DL_ARB_CHECKSUM_EN
   logic [7:0]    m_csum;
`endif

   // RAM responder and CPU agent state
   int r_cnt      = -1;
   int r_lat      = 0;    // 0 = random latency 1..4
   int r_data     = -1;   // -1 = random read data
   bit r_stall    = 1'b0;
   bit cpu_auto   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_owner = 0; m_req = 0; m_we = 0; m_ack = 0; m_ovf = 0; m_act_prev = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
`ifdef DL_ARB_CHECKSUM_EN
      m_csum = '0;
`endif
   endtask

   // Advance the model across one rising edge using the inputs currently driven.
   task automatic model_step();
      bit          rise;
      bit          hold;
      bit          drop;
      logic [32:0] head;
      logic [7:0]  add;
      rise = dl_active && !m_act_prev;
      hold = dl_active || (mq.size() != 0);
      drop = 1'b0;
      add  = 8'h00;
      m_act_prev = dl_active;
      m_ack = 1'b0;
      if (m_owner == 0) begin
         if (mq.size() != 0) begin
            head = mq.pop_front();
            m_owner = 1; m_req = 1; m_we = 1;
            m_addr = head[32:8]; m_wdata = head[7:0];
         end else if (cpu_req && !hold) begin
            m_owner = 2; m_req = 1; m_we = cpu_we;
            m_addr = cpu_addr; m_wdata = cpu_wdata;
         end
      end else if (ram_ack) begin
         if (m_owner == 1) add = m_wdata;
         else begin
            m_ack = 1'b1;
            if (!m_we) m_rdata = ram_rdata;
         end
         m_owner = 0; m_req = 0; m_we = 0;
      end
      if (dl_wr) begin
         if (mq.size() < DEPTH) mq.push_back({dl_addr, dl_data});
         else drop = 1'b1;
      end
      m_ovf = (m_ovf && !rise) || drop;
`ifdef DL_ARB_CHECKSUM_EN
      m_csum = (rise ? 8'h00 : m_csum) + add;
`endif
   endtask

   task automatic compare();
      chk("ram_req", 32'(ram_req), 32'(m_req));
      if (m_req) begin
         chk("ram_we", 32'(ram_we), 32'(m_we));
         chk("ram_addr", 32'(ram_addr), 32'(m_addr));
         chk("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
      end
      chk("cpu_ack", 32'(cpu_ack), 32'(m_ack));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
      chk("dl_overflow", 32'(dl_overflow), 32'(m_ovf));
      chk("cpu_hold", 32'(cpu_hold), 32'(dl_active || (mq.size() != 0)));
`ifdef DL_ARB_CHECKSUM_EN
      chk("dl_csum", 32'(dl_csum), 32'(m_csum));
`endif
   endtask

   task automatic ram_drive();
      if (ram_ack) ram_ack = 1'b0;
      else if (ram_req && r_cnt < 0) r_cnt = (r_lat > 0) ? r_lat : $urandom_range(1, 4);
      ram_rdata = 8'($urandom);
      if (r_cnt > 0 && !r_stall) begin
         r_cnt--;
         if (r_cnt == 0) begin
            ram_ack = 1'b1;
            if (r_data >= 0) ram_rdata = 8'(r_data);
            r_cnt = -1;
         end
      end
   endtask

   task automatic cpu_drive();
      if (!cpu_auto) return;
      if (cpu_req) begin
         if (cpu_ack) cpu_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
         cpu_req   = 1'b1;
         cpu_we    = 1'($urandom);
         cpu_addr  = AW'($urandom);
         cpu_wdata = 8'($urandom);
      end
   endtask

   // One clock: respond, step the model, cross the edge, compare at the falling edge.
   task automatic tick();
      ram_drive();
      cpu_drive();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare();
      dl_wr = 1'b0;
   endtask

   task automatic dl_push(input logic [AW-1:0] a, input logic [7:0] d);
      dl_wr = 1'b1; dl_addr = a; dl_data = d;
      tick();
   endtask

   int n;
   bit seen;

   initial begin
      reset_n = 1'b0; dl_active = 0; dl_wr = 0; dl_addr = '0; dl_data = '0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      ram_rdata = '0; ram_ack = 0;
      model_reset();
      @(negedge clk); @(negedge clk);
      #1;
      chk("rst_ram_req", 32'(ram_req), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      chk("rst_ram_wdata", 32'(ram_wdata), 0);
      chk("rst_cpu_ack", 32'(cpu_ack), 0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
      chk("rst_dl_overflow", 32'(dl_overflow), 0);
      chk("rst_cpu_hold", 32'(cpu_hold), 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Single download byte, RAM latency 2
      r_lat = 2;
      dl_active = 1'b1;
      dl_push(25'h10, 8'hA5);
      chk("single_req_lat0", 32'(ram_req), 0);
      chk("single_hold", 32'(cpu_hold), 1);
      tick();
      chk("single_req", 32'(ram_req), 1);
      chk("single_we", 32'(ram_we), 1);
      chk("single_addr", 32'(ram_addr), 32'h10);
      chk("single_wdata", 32'(ram_wdata), 32'hA5);
      dl_active = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("single_done_req", 32'(ram_req), 0);
      chk("single_done_hold", 32'(cpu_hold), 0);

      // Overflow: six back-to-back strobes while the first write stalls
      r_lat = 20;
      dl_active = 1'b1;
      for (int i = 0; i < 6; i++) dl_push(AW'(32'h100 + i), 8'(8'h30 + i));
      chk("ovf_set", 32'(dl_overflow), 1);
      r_lat = 1;
      for (int i = 0; i < 40; i++) tick();
      dl_active = 1'b0;
      tick();
      chk("ovf_sticky", 32'(dl_overflow), 1);
      dl_active = 1'b1;
      tick();
      chk("ovf_clear", 32'(dl_overflow), 0);
      dl_active = 1'b0;
      tick();

      // CPU read, latency 3
      r_lat = 3; r_data = 8'h5A;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h1234; cpu_wdata = 8'h00;
      tick();
      chk("cpu_rd_req", 32'(ram_req), 1);
      chk("cpu_rd_we", 32'(ram_we), 0);
      chk("cpu_rd_addr", 32'(ram_addr), 32'h1234);
      n = 0;
      while (!cpu_ack && n < 20) begin tick(); n++; end
      chk("cpu_rd_latency", 32'(n), 3);
      chk("cpu_rd_data", 32'(cpu_rdata), 32'h5A);
      cpu_req = 1'b0; r_data = -1;
      tick();
      chk("cpu_ack_pulse", 32'(cpu_ack), 0);
      chk("cpu_rd_hold", 32'(cpu_rdata), 32'h5A);

      // Priority: FIFO wins, CPU waits for dl_active low and an empty FIFO
      r_lat = 0;
      dl_active = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h55; cpu_wdata = 8'h99;
      dl_push(25'h77, 8'h3C);
      tick();
      chk("prio_dl_first_we", 32'(ram_we), 1);
      chk("prio_dl_first_addr", 32'(ram_addr), 32'h77);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin tick(); if (cpu_ack) seen = 1'b1; end
      chk("prio_cpu_stalled", 32'(seen), 0);
      dl_active = 1'b0;
      n = 0;
      while (!cpu_ack && n < 20) begin tick(); n++; end
      chk("prio_cpu_served", 32'(cpu_ack), 1);
      cpu_req = 1'b0;
      tick();

      // Async reset in the middle of a download write, then a stray ram_ack
      r_stall = 1'b1;
      dl_push(25'h99, 8'h11);
      tick();
      chk("rstmid_req_before", 32'(ram_req), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("rstmid_req_drop", 32'(ram_req), 0);
      chk("rstmid_hold", 32'(cpu_hold), 0);
      chk("rstmid_addr", 32'(ram_addr), 0);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      r_cnt = -1; r_stall = 1'b0;
      ram_ack = 1'b1;
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare();
      ram_ack = 1'b0;
      chk("late_ack_no_req", 32'(ram_req), 0);
      chk("late_ack_no_cpu_ack", 32'(cpu_ack), 0);
      for (int i = 0; i < 3; i++) tick();

`ifdef DL_ARB_CHECKSUM_EN
      // Checksum over three bytes after a fresh download start
      dl_active = 1'b1;
      dl_push(25'h1, 8'hFF);
      dl_push(25'h2, 8'h02);
      dl_push(25'h3, 8'h10);
      for (int i = 0; i < 20; i++) tick();
      chk("csum_literal", 32'(dl_csum), 32'h11);
      dl_active = 1'b0;
      tick();
`endif

      // Randomised traffic
      cpu_auto = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 59) == 0) dl_active = ~dl_active;
         dl_wr   = ($urandom_range(0, 2) == 0);
         dl_addr = AW'($urandom);
         dl_data = 8'($urandom);
         tick();
      end

      // Drain and let any pending CPU access finish
      cpu_auto = 1'b0;
      dl_active = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (cpu_ack) cpu_req = 1'b0;
      end
      chk("drain_cpu_done", 32'(cpu_req), 0);
      chk("drain_idle", 32'(ram_req), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
